// File: rtl/motoro3_commutator_ramp.sv
// Six-step BLDC commutation sequencer with runtime period, linear period ramp,
// direction select, dead-time insertion and brake. State updates on the falling clock edge.
module motoro3_commutator_ramp #(
    parameter int CNT_W  = 25,
    parameter int DEAD_W = 8,
    parameter int RND_W  = 48
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              m3start,
    input  logic              m3stop,
    input  logic              m3dir,
    input  logic [CNT_W-1:0]  m3period_init,
    input  logic [CNT_W-1:0]  m3period_tgt,
    input  logic [CNT_W-1:0]  m3ramp,
    input  logic [DEAD_W-1:0] m3dead,
    output logic              aE,
    output logic              bE,
    output logic              cE,
    output logic              aH1_L0,
    output logic              bH1_L0,
    output logic              cH1_L0,
    output logic [3:0]        m3step,
    output logic [CNT_W-1:0]  m3cnt,
    output logic              m3cntLast1,
    output logic [CNT_W-1:0]  m3period_cur,
    output logic              m3atSpeed,
    output logic              m3dead_act,
    output logic [RND_W-1:0]  roundCNT
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD, S_BRAKE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        step_q, step_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [RND_W-1:0]  round_q, round_d;
    logic [2:0]        e_q, e_d;
    logic [2:0]        h_q, h_d;
    logic              dead_act_q, dead_act_d;
    logic              start_d_q;

    logic              up;
    logic              last1;
    logic [CNT_W-1:0]  init_c, tgt_c, per_ramp;
    logic [3:0]        step_nxt;
    logic              wrap;
    logic [CNT_W:0]    cur_x, tgt_x, rmp_x, sum_x;

    assign up     = m3start & ~start_d_q;
    assign last1  = (cnt_q <= CNT_W'(1));
    assign init_c = (m3period_init < CNT_W'(2)) ? CNT_W'(2) : m3period_init;
    assign tgt_c  = (m3period_tgt  < CNT_W'(2)) ? CNT_W'(2) : m3period_tgt;

    always_comb begin
        if (m3dir) begin
            step_nxt = (step_q == 4'd1) ? 4'd6 : step_q - 4'd1;
            wrap     = (step_q == 4'd1);
        end else begin
            step_nxt = (step_q == 4'd6) ? 4'd1 : step_q + 4'd1;
            wrap     = (step_q == 4'd6);
        end
    end

    // Ramp in one extra bit so neither direction can wrap past the target.
    always_comb begin
        cur_x = {1'b0, per_q};
        tgt_x = {1'b0, tgt_c};
        rmp_x = {1'b0, m3ramp};
        sum_x = cur_x + rmp_x;
        if (cur_x > tgt_x)
            per_ramp = ((cur_x - tgt_x) <= rmp_x) ? tgt_c : per_q - m3ramp;
        else if (cur_x < tgt_x)
            per_ramp = (sum_x >= tgt_x) ? tgt_c : sum_x[CNT_W-1:0];
        else
            per_ramp = per_q;
    end

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            cnt_q      <= '0;
            per_q      <= '0;
            round_q    <= '0;
            e_q        <= '0;
            h_q        <= '0;
            dead_act_q <= 1'b0;
            start_d_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            round_q    <= round_d;
            e_q        <= e_d;
            h_q        <= h_d;
            dead_act_q <= dead_act_d;
            start_d_q  <= m3start;
        end
    end

    always_comb begin
        state_d = state_q;
        if (m3stop) begin
            state_d = S_BRAKE;
        end else begin
            case (state_q)
                S_IDLE:  if (up) state_d = S_RUN;
                S_RUN: begin
                    if (!m3start)                          state_d = S_IDLE;
                    else if (last1 && (m3dead != '0))      state_d = S_DEAD;
                end
                S_DEAD: begin
                    if (!m3start)   state_d = S_IDLE;
                    else if (last1) state_d = S_RUN;
                end
                S_BRAKE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        step_d  = step_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        round_d = round_q;
        if (m3stop) begin
            step_d = 4'd7;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (up) begin
                        step_d = m3dir ? 4'd6 : 4'd1;
                        per_d  = init_c;
                        cnt_d  = init_c;
                    end
                end
                S_RUN, S_DEAD: begin
                    if (!m3start) begin
                        step_d  = 4'd0;
                        cnt_d   = '0;
                        round_d = '0;
                    end else if (last1 && (state_q == S_RUN)) begin
                        step_d  = step_nxt;
                        per_d   = per_ramp;
                        round_d = wrap ? round_q + RND_W'(1) : round_q;
                        cnt_d   = (m3dead != '0) ? CNT_W'(m3dead) : per_ramp;
                    end else if (last1) begin
                        cnt_d = per_q;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    step_d = 4'd0;
                    cnt_d  = '0;
                end
            endcase
        end
    end

    // Phase outputs follow the next state and step so they move on the same edge as m3step.
    always_comb begin
        e_d        = 3'b000;
        h_d        = 3'b000;
        dead_act_d = 1'b0;
        case (state_d)
            S_RUN: begin
                case (step_d)
                    4'd1:    begin e_d = 3'b101; h_d = 3'b100; end
                    4'd2:    begin e_d = 3'b011; h_d = 3'b010; end
                    4'd3:    begin e_d = 3'b110; h_d = 3'b010; end
                    4'd4:    begin e_d = 3'b101; h_d = 3'b001; end
                    4'd5:    begin e_d = 3'b011; h_d = 3'b001; end
                    4'd6:    begin e_d = 3'b110; h_d = 3'b100; end
                    default: begin e_d = 3'b000; h_d = 3'b000; end
                endcase
            end
            S_DEAD:  dead_act_d = 1'b1;
            S_BRAKE: e_d = 3'b111;
            default: ;
        endcase
    end

    assign {aE, bE, cE}             = e_q;
    assign {aH1_L0, bH1_L0, cH1_L0} = h_q;
    assign m3step       = step_q;
    assign m3cnt        = cnt_q;
    assign m3period_cur = per_q;
    assign roundCNT     = round_q;
    assign m3dead_act   = dead_act_q;
    assign m3cntLast1   = ((state_q == S_RUN) || (state_q == S_DEAD)) && last1;
    assign m3atSpeed    = (state_q == S_RUN) && (per_q == tgt_c);

endmodule
